// File: rtl/sha256_message_unbuild.sv
// sha256_message_unbuild
//   Strips SHA-256 padding from a stream of 512-bit padded blocks and recovers
//   the original message data plus its bit length.
//
//   Ports:
//     clk, nrst        clock, asynchronous active-low reset
//     en               block enable; when low all state is frozen
//     sync_rst         synchronous active-high reset
//     data_in*         padded block input stream (valid/ready, last marks the
//                      block carrying the 64-bit length field)
//     data_out*        recovered message blocks, padding bits zeroed
//     cfg_size/last/valid/ready
//                      one word per packet carrying the message length L
//     err              sticky flag: block count disagreed with the length field
module sha256_message_unbuild (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         sync_rst,
  input  logic [511:0] data_in,
  input  logic         data_in_last,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  output logic [511:0] data_out,
  output logic         data_out_last,
  output logic         data_out_valid,
  input  logic         data_out_ready,
  output logic [63:0]  cfg_size,
  output logic         cfg_last,
  output logic         cfg_valid,
  input  logic         cfg_ready,
  output logic         err
);

  typedef enum logic [1:0] {S_RECV, S_TAIL, S_WAIT} state_t;

  state_t       r_state;
  logic [511:0] r_hold;
  logic         r_hv;
  logic [55:0]  r_cnt;
  logic [511:0] r_oData;
  logic         r_oLast;
  logic         r_oValid;
  logic [63:0]  r_cfgSize;
  logic         r_cfgValid;
  logic         r_err;
  logic         r_started;

  logic         w_inXfer;
  logic         w_outXfer;
  logic         w_cfgXfer;
  logic [63:0]  w_len;
  logic [8:0]   w_rem;
  logic         w_padOnly;
  logic [64:0]  w_sum;
  logic [55:0]  w_needBlocks;
  logic [55:0]  w_count;
  logic [9:0]   w_keepBits;
  logic [511:0] w_mask;

  // r_started keeps the input closed for the first cycle after reset release.
  assign data_in_ready = en & r_started & (r_state == S_RECV) & ~r_oValid & ~r_cfgValid;

  assign w_inXfer  = data_in_valid & data_in_ready;
  assign w_outXfer = en & r_oValid & data_out_ready;
  assign w_cfgXfer = en & r_cfgValid & cfg_ready;

  // Length decode on the last block: expected block count is
  // ceil((L + 65) / 512) = (L + 576) >> 9, computed one bit wider to avoid overflow.
  assign w_len        = data_in[63:0];
  assign w_rem        = w_len[8:0];
  assign w_padOnly    = (w_rem >= 9'd448) || ((w_rem == 9'd0) && (w_len != 64'd0));
  assign w_sum        = {1'b0, w_len} + 65'd576;
  assign w_needBlocks = w_sum[64:9];
  assign w_count      = r_cnt + 56'd1;

  // Keep the top k message bits of the final data block; L=0 keeps nothing.
  assign w_keepBits = (w_rem == 9'd0) ? 10'd512 : {1'b0, w_rem};
  assign w_mask     = (w_len == 64'd0) ? '0 : ~({512{1'b1}} >> w_keepBits);

  assign data_out       = r_oData;
  assign data_out_last  = r_oLast;
  assign data_out_valid = r_oValid;
  assign cfg_size       = r_cfgSize;
  assign cfg_last       = 1'b1;
  assign cfg_valid      = r_cfgValid;
  assign err            = r_err;

  // Single state machine: hold register H feeds output register O one block
  // behind the input so the final data block can be masked once the length
  // field (which may sit in a padding-only block) has been seen.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_RECV;
      r_hold     <= '0;
      r_hv       <= 1'b0;
      r_cnt      <= '0;
      r_oData    <= '0;
      r_oLast    <= 1'b0;
      r_oValid   <= 1'b0;
      r_cfgSize  <= '0;
      r_cfgValid <= 1'b0;
      r_err      <= 1'b0;
      r_started  <= 1'b0;
    end else if (sync_rst) begin
      r_state    <= S_RECV;
      r_hold     <= '0;
      r_hv       <= 1'b0;
      r_cnt      <= '0;
      r_oData    <= '0;
      r_oLast    <= 1'b0;
      r_oValid   <= 1'b0;
      r_cfgSize  <= '0;
      r_cfgValid <= 1'b0;
      r_err      <= 1'b0;
      r_started  <= 1'b0;
    end else if (en) begin
      r_started <= 1'b1;
      if (w_outXfer) r_oValid <= 1'b0;
      if (w_cfgXfer) r_cfgValid <= 1'b0;
      case (r_state)
        S_RECV: begin
          if (w_inXfer) begin
            if (!data_in_last) begin
              if (r_hv) begin
                r_oData  <= r_hold;
                r_oLast  <= 1'b0;
                r_oValid <= 1'b1;
              end
              r_hold <= data_in;
              r_hv   <= 1'b1;
              r_cnt  <= w_count;
            end else begin
              r_cfgSize  <= w_len;
              r_cfgValid <= 1'b1;
              if (w_count != w_needBlocks) r_err <= 1'b1;
              r_oValid <= 1'b1;
              if (w_padOnly) begin
                // Final block holds only padding: it is dropped.
                r_oData <= r_hv ? (r_hold & w_mask) : '0;
                r_oLast <= 1'b1;
                r_hv    <= 1'b0;
                r_state <= S_WAIT;
              end else if (r_hv) begin
                // Two blocks still to emit; the masked tail waits in H.
                r_oData <= r_hold;
                r_oLast <= 1'b0;
                r_hold  <= data_in & w_mask;
                r_state <= S_TAIL;
              end else begin
                r_oData <= data_in & w_mask;
                r_oLast <= 1'b1;
                r_state <= S_WAIT;
              end
            end
          end
        end
        S_TAIL: begin
          if (!r_oValid || w_outXfer) begin
            r_oData  <= r_hold;
            r_oLast  <= 1'b1;
            r_oValid <= 1'b1;
            r_hv     <= 1'b0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Both the last data block and the cfg word must be gone.
          if ((!r_oValid || w_outXfer) && (!r_cfgValid || w_cfgXfer)) begin
            r_state <= S_RECV;
            r_cnt   <= '0;
          end
        end
        default: r_state <= S_RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_message_unbuild.sv
// tb_sha256_message_unbuild
//   Scoreboard bench: each packet's expected data blocks and cfg word are
//   derived from the padded packet as a whole and queued; a monitor pops and
//   compares whenever the DUT completes an output transfer.
module tb_sha256_message_unbuild;

  logic         clk = 1'b0;
  logic         nrst;
  logic         en;
  logic         sync_rst;
  logic [511:0] data_in;
  logic         data_in_last;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [511:0] data_out;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready;
  logic [63:0]  cfg_size;
  logic         cfg_last;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         err;

  sha256_message_unbuild dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .sync_rst       (sync_rst),
    .data_in        (data_in),
    .data_in_last   (data_in_last),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .cfg_size       (cfg_size),
    .cfg_last       (cfg_last),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         last;
  } outExp_t;

  typedef struct {
    logic [63:0] size;
    logic        err;
  } cfgExp_t;

  outExp_t      outQ[$];
  cfgExp_t      cfgQ[$];
  logic [511:0] pktBlocks[$];

  int   compared   = 0;
  int   mismatched = 0;
  logic errModel   = 1'b0;
  bit   enRandom   = 1'b0;
  bit   bpRandom   = 1'b0;
  bit   armStall   = 1'b0;
  int   stallLeft  = 0;

  logic [511:0] prevData;
  logic         prevLast;
  bit           prevPend = 1'b0;

  // Keep the first k message bits (bit 511 is first) and clear the rest.
  function automatic logic [511:0] keepTop(input logic [511:0] x, input int k);
    logic [511:0] y;
    y = '0;
    for (int i = 0; i < k; i++) y[511-i] = x[511-i];
    return y;
  endfunction

  function automatic logic [511:0] randBlock();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got timeout expected completion", name);
  endtask

  // Reference model over the whole packet: the blocks that carry message
  // bits come out in order, only the final one truncated to the message
  // length; a trailing padding-only block is dropped.
  task automatic pushExpected(input logic [63:0] len);
    int n;
    int r;
    bit padOnly;
    int m;
    int k;
    longint unsigned need;
    outExp_t o;
    cfgExp_t c;
    n       = pktBlocks.size();
    r       = int'(len % 64'd512);
    padOnly = (r >= 448) || (r == 0 && len != 64'd0);
    m       = padOnly ? n - 1 : n;
    k       = (len == 64'd0) ? 0 : ((r == 0) ? 512 : r);
    need    = (len + 64'd65 + 64'd511) / 64'd512;
    if (m <= 0) begin
      o.data = '0;
      o.last = 1'b1;
      outQ.push_back(o);
    end else begin
      for (int i = 0; i < m; i++) begin
        o.data = (i == m - 1) ? keepTop(pktBlocks[i], k) : pktBlocks[i];
        o.last = (i == m - 1);
        outQ.push_back(o);
      end
    end
    if (longint'(n) != longint'(need)) errModel = 1'b1;
    c.size = len;
    c.err  = errModel;
    cfgQ.push_back(c);
  endtask

  task automatic sendBlock(input logic [511:0] blk, input logic last);
    bit accepted;
    int waited;
    data_in       = blk;
    data_in_last  = last;
    data_in_valid = 1'b1;
    accepted      = 1'b0;
    waited        = 0;
    while (!accepted) begin
      @(negedge clk);
      accepted = data_in_ready;
      @(posedge clk);
      #1;
      waited++;
      if (waited > 3000) begin
        failNow("input accept");
        data_in_valid = 1'b0;
        return;
      end
    end
    data_in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [63:0] len);
    int n;
    pushExpected(len);
    n = pktBlocks.size();
    for (int i = 0; i < n; i++) begin
      sendBlock(pktBlocks[i], i == n - 1);
      if (bpRandom) repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic randPacket(input bit mismatch);
    logic [63:0]  len;
    logic [511:0] b;
    int n;
    len = 64'($urandom_range(0, 3000));
    n   = int'((len + 64'd576) / 64'd512);
    if (mismatch) n = (n > 1 && $urandom_range(0, 1) == 1) ? n - 1 : n + int'($urandom_range(1, 2));
    pktBlocks.delete();
    for (int i = 0; i < n; i++) begin
      b = randBlock();
      if (i == n - 1) b[63:0] = len;
      pktBlocks.push_back(b);
    end
    applyStimulus(len);
  endtask

  task automatic abcPacket();
    logic [511:0] b;
    b = '0;
    b[511:488] = 24'h616263;
    b[487]     = 1'b1;
    b[63:0]    = 64'd24;
    pktBlocks.delete();
    pktBlocks.push_back(b);
    applyStimulus(64'd24);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((outQ.size() != 0 || cfgQ.size() != 0) && w < 5000) begin
      @(posedge clk);
      w++;
    end
    if (outQ.size() != 0 || cfgQ.size() != 0) failNow("drain");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " data_out"}, data_out, '0);
    checkOutput({tag, " data_out_last"}, 512'(data_out_last), 512'd0);
    checkOutput({tag, " data_out_valid"}, 512'(data_out_valid), 512'd0);
    checkOutput({tag, " cfg_size"}, 512'(cfg_size), 512'd0);
    checkOutput({tag, " cfg_last"}, 512'(cfg_last), 512'd1);
    checkOutput({tag, " cfg_valid"}, 512'(cfg_valid), 512'd0);
    checkOutput({tag, " err"}, 512'(err), 512'd0);
    checkOutput({tag, " data_in_ready"}, 512'(data_in_ready), 512'd0);
  endtask

  // Sink back-pressure and enable, all changed just after the rising edge.
  initial begin
    en             = 1'b0;
    data_out_ready = 1'b0;
    cfg_ready      = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (armStall && data_out_valid) begin
        stallLeft = 5;
        armStall  = 1'b0;
      end
      if (stallLeft > 0) begin
        data_out_ready = 1'b0;
        stallLeft--;
      end else begin
        data_out_ready = bpRandom ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      cfg_ready = bpRandom ? ($urandom_range(0, 1) == 1) : 1'b1;
      en        = enRandom ? ($urandom_range(0, 7) != 0) : 1'b1;
    end
  end

  // Monitor: handshake rules, payload stability, and scoreboard pops.
  always @(negedge clk) begin
    outExp_t o;
    cfgExp_t c;
    if (nrst && !sync_rst) begin
      if (!en) checkOutput("ready while disabled", 512'(data_in_ready), 512'd0);
      if (data_out_valid) checkOutput("ready while O full", 512'(data_in_ready), 512'd0);
      if (prevPend && data_out_valid) begin
        checkOutput("data_out stable", data_out, prevData);
        checkOutput("data_out_last stable", 512'(data_out_last), 512'(prevLast));
      end
      if (data_out_valid && data_out_ready && en) begin
        if (outQ.size() == 0) begin
          failNow("unexpected data_out");
        end else begin
          o = outQ.pop_front();
          checkOutput("data_out", data_out, o.data);
          checkOutput("data_out_last", 512'(data_out_last), 512'(o.last));
        end
      end
      if (cfg_valid && cfg_ready && en) begin
        if (cfgQ.size() == 0) begin
          failNow("unexpected cfg");
        end else begin
          c = cfgQ.pop_front();
          checkOutput("cfg_size", 512'(cfg_size), 512'(c.size));
          checkOutput("err", 512'(err), 512'(c.err));
          checkOutput("cfg_last", 512'(cfg_last), 512'd1);
        end
      end
      prevPend = data_out_valid && !(data_out_ready && en);
      prevData = data_out;
      prevLast = data_out_last;
    end else begin
      prevPend = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [511:0] b;
    nrst          = 1'b0;
    sync_rst      = 1'b0;
    data_in       = '0;
    data_in_last  = 1'b0;
    data_in_valid = 1'b0;
    #2;
    checkResetState("power-on");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    #1;
    checkOutput("ready after release", 512'(data_in_ready), 512'd0);
    repeat (2) @(posedge clk);
    #1;

    // "abc", L=24
    abcPacket();

    // L=448: length-only second block
    pktBlocks.delete();
    pktBlocks.push_back(randBlock());
    b = '0; b[63:0] = 64'd448;
    pktBlocks.push_back(b);
    applyStimulus(64'd448);

    // L=512: second block is pure padding
    pktBlocks.delete();
    pktBlocks.push_back(randBlock());
    b = '0; b[511] = 1'b1; b[63:0] = 64'd512;
    pktBlocks.push_back(b);
    applyStimulus(64'd512);

    // L=0: single all-padding block decodes to zeros
    pktBlocks.delete();
    b = '0; b[511] = 1'b1;
    pktBlocks.push_back(b);
    applyStimulus(64'd0);
    drain();

    // L=1000 with a 5-cycle sink stall after the first output
    armStall = 1'b1;
    pktBlocks.delete();
    pktBlocks.push_back(randBlock());
    pktBlocks.push_back(randBlock());
    b = '0; b[63:0] = 64'd1000;
    pktBlocks.push_back(b);
    applyStimulus(64'd1000);
    drain();

    // Randomized consistent packets under back-pressure and enable gaps
    bpRandom = 1'b1;
    enRandom = 1'b1;
    for (int p = 0; p < 20; p++) randPacket(1'b0);
    drain();

    // Single block claiming L=1024: count mismatch
    pktBlocks.delete();
    b = '0; b[63:0] = 64'd1024;
    pktBlocks.push_back(b);
    applyStimulus(64'd1024);
    for (int p = 0; p < 4; p++) randPacket(1'b1);
    drain();

    // Async reset after the first block of a 3-block packet
    bpRandom = 1'b0;
    enRandom = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sendBlock(randBlock(), 1'b0);
    repeat (3) @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    checkResetState("async reset");
    errModel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    checkOutput("ready after release 2", 512'(data_in_ready), 512'd0);
    @(posedge clk);
    #1;
    abcPacket();
    drain();

    // Set err again, then clear it with the synchronous reset
    pktBlocks.delete();
    b = '0; b[63:0] = 64'd2000;
    pktBlocks.push_back(b);
    applyStimulus(64'd2000);
    drain();
    sync_rst = 1'b1;
    @(posedge clk);
    #1;
    sync_rst = 1'b0;
    errModel = 1'b0;
    checkResetState("sync reset");
    @(posedge clk);
    #1;
    abcPacket();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sha256_message_unbuild.md
SHA256_MESSAGE_UNBUILD -- requirements
Module: sha256_message_unbuild

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk input, nrst input.
- clk  in  1  rising-edge clock for all state.
- nrst  in  1  asynchronous, active-low reset.
REQ-002 SHALL have the following control inputs:
- en  in  1  block enable.
- sync_rst  in  1  synchronous reset, active high.
REQ-003 SHALL have the following padded-block input stream:
- data_in  in  512  padded SHA-256 block; bit 511 is the first message bit.
- data_in_last  in  1  final block of a packet.
- data_in_valid  in  1  input valid.
- data_in_ready  out  1  input ready.
REQ-004 SHALL have the following recovered-data output stream:
- data_out  out  512  message data, with padding bits cleared to zero.
- data_out_last  out  1  final data block of the packet.
- data_out_valid  out  1  output valid.
- data_out_ready  in  1  output ready.
REQ-005 SHALL have the following recovered-configuration output:
- cfg_size  out  64  message length L in bits.
- cfg_last  out  1  constant 1 (one cfg word per packet).
- cfg_valid  out  1  cfg valid.
- cfg_ready  in  1  cfg ready.
- err  out  1  sticky block-count mismatch flag.

Function
REQ-006 SHALL complete a transfer on any stream only in a cycle where valid=1 and ready=1.
REQ-007 SHALL hold valid and payload stable until that transfer completes.
REQ-008 SHALL, while en=0, drive data_in_ready=0, freeze all state, and complete no transfer.
REQ-009 SHALL hold one block in a hold register H with flag hv, plus a single output register O.
REQ-010 SHALL drive data_in_ready=1 only in state S_RECV with O empty and cfg_valid=0.
REQ-011 SHALL, on accepting a non-last block: if hv=1, load O with H (last=0); then load H with the input block, set hv=1, and increment 56-bit block counter cnt.
REQ-012 SHALL, on accepting a last block, take L = data_in[63:0], r = L mod 512, N = ceil((L+65)/512), and final count c = cnt+1.
REQ-013 SHALL, on that last block, assert cfg_valid with cfg_size=L in the next cycle.
REQ-014 SHALL set err if c != N.
REQ-015 SHALL classify the last block as padding-only when r>=448, or when r=0 and L>0.
REQ-016 SHALL, for a padding-only last block with hv=1: load O with mask(H) and last=1, clear hv, and discard the input block.
REQ-017 SHALL, for a padding-only last block with hv=0: load O with 512'd0 and last=1.
REQ-018 SHALL, for other last blocks with hv=1: load O with H (last=0), load H with the masked input, and go to S_TAIL.
REQ-019 SHALL, in S_TAIL, when O empties, load O with H (last=1), clear hv, and go to S_WAIT.
REQ-020 SHALL, for other last blocks with hv=0: load O with the masked input and last=1.
REQ-021 SHALL define mask(x) as keeping bits [511:512-k] with k = (r==0 ? 512 : r) and zeroing all lower bits; L=0 yields an all-zero block.
REQ-022 SHALL, in S_WAIT, return to S_RECV and clear cnt once both the final data_out transfer and the cfg transfer have completed; the two may complete in either order or together.
REQ-023 SHALL have input-to-O latency of 1 cycle, and SHALL lose no block under any back-pressure pattern.

Reset
REQ-024 SHALL, on nrst low asynchronously or sync_rst high at a clock edge, including mid-packet, reset to: state S_RECV, hv=0, cnt=0, O empty, data_out=0, data_out_last=0, data_out_valid=0, cfg_size=0, cfg_last=1, cfg_valid=0, err=0, data_in_ready=0.
REQ-025 SHALL keep data_in_ready=0 for the first cycle after reset release.
REQ-026 SHALL clear err only by reset.

Verification
REQ-027 SHALL cover: L=24 single block 0x6162638000...0018 -> data_out=0x616263 followed by zeros, last=1; cfg_size=24; err=0.
REQ-028 SHALL cover: L=448, 2 blocks, second block all-zero except length 0x1C0 -> one output block with bits[63:0] cleared, last=1; cfg_size=448.
REQ-029 SHALL cover: L=512, 2 blocks, second block 0x80...0200 -> first block output unchanged, last=1; second block discarded.
REQ-030 SHALL cover: L=1000, 3 blocks, data_out_ready low 5 cycles after the first output -> data_in_ready=0 throughout the stall; 2 outputs, second with bits[23:0] zero and last=1.
REQ-031 SHALL cover: single block with L=1024 -> err=1; data_out=0, last=1; cfg_size=1024.
REQ-032 SHALL cover: nrst pulsed after block 1 of a 3-block packet -> all outputs at reset values; next "abc" packet decodes exactly as in REQ-027.
